cal1d_fp16_pool_seq: RTL and testbench
======================================

Name: cal1d_fp16_pool_seq

Overview:
- Window sequencer directly upstream of the 4-lane fp17 pool-sum adder stage in the PDP 1D pooling path.
- Accepts a stream of 4-lane fp17 elements and groups them into windows of cfg_kernel_width+1 elements.
- Chains each window through the adder one add at a time, using a running accumulator as operand A and the new element as operand B, then emits one 4-lane window sum.
- Only one add is in flight at a time, so the block is independent of the adder's internal latency.

Parameters:
LANE_NUM, 4, number of fp17 lanes packed per beat
DW, 17, bits per lane (fp17: 1 sign, 6 exp bias 31, 10 mantissa)
KW_BITS, 3, width of kernel-width config (kernel 1..8)

Ports:
nvdla_op_gated_clk_fp16  in   1                clock
nvdla_core_rst           in   1                async reset, active-high
cfg_kernel_width         in   KW_BITS          kernel size minus 1; sampled at first beat of each window
pool_in_pvld             in   1                input element valid
pool_in_prdy             out  1                input element ready
pool_in_data             in   LANE_NUM*DW      lane i at [i*DW +: DW]
sum_in_pvld              out  1                operand pair valid to adder
sum_in_prdy              in   1                adder accepts operand pair
sum_a                    out  LANE_NUM*DW      operand A (accumulator)
sum_b                    out  LANE_NUM*DW      operand B (new element)
sum_out_pvld             in   1                adder result valid
sum_out_prdy             out  1                result ready
sum_z                    in   LANE_NUM*DW      adder result
pool_out_pvld            out  1                window sum valid
pool_out_prdy            in   1                downstream ready
pool_out_data            out  LANE_NUM*DW      window sum (registered accumulator)

Behaviour:
- Registers: state, acc[LANE_NUM*DW], remaining-count rem[KW_BITS]. All reset to IDLE / 0 / 0.
- Output values during reset: pool_in_prdy=0, sum_in_pvld=0, sum_out_prdy=0, pool_out_pvld=0, data outputs 0.
- IDLE:
  - pool_in_prdy=1.
  - On pool_in_pvld: acc<=pool_in_data and rem<=cfg_kernel_width.
  - If cfg_kernel_width==0, go to OUTPUT; otherwise go to ISSUE.
- ISSUE:
  - Zero-buffer pass-through: sum_in_pvld=pool_in_pvld, pool_in_prdy=sum_in_prdy, sum_a=acc, sum_b=pool_in_data.
  - On handshake (pool_in_pvld & sum_in_prdy): rem<=rem-1, go to WAIT.
- WAIT:
  - sum_out_prdy=1, pool_in_prdy=0.
  - On sum_out_pvld: acc<=sum_z. If rem==0, go to OUTPUT; otherwise go to ISSUE.
- OUTPUT:
  - pool_out_pvld=1, pool_out_data=acc, pool_in_prdy=0.
  - On pool_out_prdy, go to IDLE.
  - Data is held stable while stalled.
- Outside ISSUE: sum_in_pvld=0 and sum_a/sum_b=0. Outside WAIT: sum_out_prdy=0, and stray results are not consumed.
- Latency:
  - K=1: pool_out_pvld rises 1 cycle after input accept.
  - K>1: pool_out_pvld rises 1 cycle after the final result handshake.
  - Throughput is 1 window per (K-1)*(adder latency+1)+2 cycles minimum.
- cfg_kernel_width changes mid-window have no effect until the next IDLE accept.
- Back-to-back windows: there is a 1-cycle IDLE bubble after the OUTPUT accept.
- No arithmetic is performed in this block; lanes pass through untouched and packing is preserved.
- Reset asserted mid-window: immediate return to IDLE and the partial window is discarded. The bench must re-sync the adder model, since any in-flight result is dropped.

Optional Feature:
- Macro: NVDLA_PDP_POOL_SEQ_PERF_EN.
- When defined:
  - Adds output port perf_stall_cnt[31:0].
  - The counter increments every cycle that (state==ISSUE & pool_in_pvld & !sum_in_prdy) or (state==WAIT & !sum_out_pvld).
  - It saturates at 32'hFFFFFFFF and clears on reset only.
- When undefined: the port and the counter are absent, and functional behaviour is identical.

Test Plan:
- K=1 (cfg=0), input 4 lanes 17'h07C00 (1.0) -> pool_out_data lanes 17'h07C00 one cycle later; sum_in_pvld never asserted.
- K=3 (cfg=2), inputs 1.0, 1.0, 2.0 (17'h07C00, 17'h07C00, 17'h08000) with a 3-cycle adder model -> sum_a/sum_b pairs (1.0,1.0) then (2.0,2.0); output 4.0 (17'h08400) on all lanes.
- K=2 with pool_out_prdy held 0 for 5 cycles -> pool_out_pvld stays 1, data stable, pool_in_prdy=0, extra input not accepted.
- K=4 with sum_in_prdy toggling 0/1 each cycle and sum_out_pvld delayed randomly -> no operand duplication or loss; correct sum, e.g. 4x1.0 -> 17'h08400.
- Reset pulsed while in WAIT mid-window -> all outputs 0 within the reset cycle; the next window after reset sums correctly with no residue in acc.
- PERF_EN: sum_out_pvld withheld 10 cycles in WAIT -> perf_stall_cnt==10; counter preset near max -> saturates at 32'hFFFFFFFF.

Source files
------------

// File: rtl/cal1d_fp16_pool_seq.sv
// Window sequencer for the PDP 1D pool-sum adder: chains each window of 4-lane fp17 elements through the adder.
// Optional stall counter port perf_stall_cnt is enabled by defining NVDLA_PDP_POOL_SEQ_PERF_EN.
module cal1d_fp16_pool_seq #(
   parameter int LANE_NUM = 4,
   parameter int DW       = 17,
   parameter int KW_BITS  = 3
) (
   input  logic                   nvdla_op_gated_clk_fp16,
   input  logic                   nvdla_core_rst,
   input  logic [KW_BITS-1:0]     cfg_kernel_width,
   input  logic                   pool_in_pvld,
   output logic                   pool_in_prdy,
   input  logic [LANE_NUM*DW-1:0] pool_in_data,
   output logic                   sum_in_pvld,
   input  logic                   sum_in_prdy,
   output logic [LANE_NUM*DW-1:0] sum_a,
   output logic [LANE_NUM*DW-1:0] sum_b,
   input  logic                   sum_out_pvld,
   output logic                   sum_out_prdy,
   input  logic [LANE_NUM*DW-1:0] sum_z,
   output logic                   pool_out_pvld,
   input  logic                   pool_out_prdy,
   output logic [LANE_NUM*DW-1:0] pool_out_data
`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
   ,
   output logic [31:0]            perf_stall_cnt
`endif
);

   localparam int BW = LANE_NUM * DW;
   localparam logic [KW_BITS-1:0] KW_ZERO = {KW_BITS{1'b0}};
   localparam logic [KW_BITS-1:0] KW_ONE  = {{(KW_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_OUTPUT = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [BW-1:0]      acc_r;
   logic [BW-1:0]      acc_nxt_s;
   logic [KW_BITS-1:0] rem_r;
   logic [KW_BITS-1:0] rem_nxt_s;

   // Next-state, accumulator and remaining-add count.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      rem_nxt_s   = rem_r;
      case (state_r)
         ST_IDLE: begin
            if (pool_in_pvld) begin
               acc_nxt_s = pool_in_data;
               rem_nxt_s = cfg_kernel_width;
               if (cfg_kernel_width == KW_ZERO) begin
                  state_nxt_s = ST_OUTPUT;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (pool_in_pvld && sum_in_prdy) begin
               rem_nxt_s   = rem_r - KW_ONE;
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            // rem already counts the add that is in flight, so zero means this result closes the window.
            if (sum_out_pvld) begin
               acc_nxt_s = sum_z;
               if (rem_r == KW_ZERO) begin
                  state_nxt_s = ST_OUTPUT;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_OUTPUT: begin
            if (pool_out_prdy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUTPUT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            acc_nxt_s   = {BW{1'b0}};
            rem_nxt_s   = KW_ZERO;
         end
      endcase
   end

   // State, accumulator and count registers.
   always_ff @(posedge nvdla_op_gated_clk_fp16 or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state_r <= ST_IDLE;
         acc_r   <= {BW{1'b0}};
         rem_r   <= KW_ZERO;
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
         rem_r   <= rem_nxt_s;
      end
   end

   // Handshake and data outputs; reset forces everything low even before the first clock edge.
   always_comb begin
      pool_in_prdy  = 1'b0;
      sum_in_pvld   = 1'b0;
      sum_a         = {BW{1'b0}};
      sum_b         = {BW{1'b0}};
      sum_out_prdy  = 1'b0;
      pool_out_pvld = 1'b0;
      pool_out_data = {BW{1'b0}};
      if (nvdla_core_rst) begin
         pool_in_prdy = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               pool_in_prdy = 1'b1;
            end
            ST_ISSUE: begin
               sum_in_pvld  = pool_in_pvld;
               pool_in_prdy = sum_in_prdy;
               sum_a        = acc_r;
               sum_b        = pool_in_data;
            end
            ST_WAIT: begin
               sum_out_prdy = 1'b1;
            end
            ST_OUTPUT: begin
               pool_out_pvld = 1'b1;
               pool_out_data = acc_r;
            end
            default: begin
               pool_in_prdy = 1'b0;
            end
         endcase
      end
   end

`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
   logic        stall_s;
   logic [31:0] perf_cnt_r;

   assign stall_s = ((state_r == ST_ISSUE) && pool_in_pvld && !sum_in_prdy) ||
                    ((state_r == ST_WAIT) && !sum_out_pvld);

   // Saturating count of cycles blocked on the adder.
   always_ff @(posedge nvdla_op_gated_clk_fp16 or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         perf_cnt_r <= 32'h0000_0000;
      end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
         perf_cnt_r <= perf_cnt_r + 32'h0000_0001;
      end else begin
         perf_cnt_r <= perf_cnt_r;
      end
   end

   assign perf_stall_cnt = perf_cnt_r;
`endif

endmodule

// File: tb/tb_cal1d_fp16_pool_seq.sv
// Self-checking bench for cal1d_fp16_pool_seq: behavioural fp17 adder model plus operand/result scoreboards.
module tb_cal1d_fp16_pool_seq;

   localparam int BW = 68;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    cfg_kernel_width;
   logic          pool_in_pvld;
   logic          pool_in_prdy;
   logic [BW-1:0] pool_in_data;
   logic          sum_in_pvld;
   logic          sum_in_prdy;
   logic [BW-1:0] sum_a;
   logic [BW-1:0] sum_b;
   logic          sum_out_pvld;
   logic          sum_out_prdy;
   logic [BW-1:0] sum_z;
   logic          pool_out_pvld;
   logic          pool_out_prdy;
   logic [BW-1:0] pool_out_data;
`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
   logic [31:0]   perf_stall_cnt;
   logic [31:0]   perf_p0;
`endif

   int checks = 0;
   int errors = 0;

   logic [2*BW-1:0] exp_pair[$];
   logic [BW-1:0]   exp_out[$];
   logic [BW-1:0]   win[8];
   logic [16:0]     vals[4];

   // adder model controls
   int  lat_fixed   = 3;
   bit  rand_lat    = 1'b0;
   bit  prdy_toggle = 1'b0;
   bit  sum_in_seen = 1'b0;
   int  stall_obs   = 0;

   cal1d_fp16_pool_seq dut (
      .nvdla_op_gated_clk_fp16 (clk),
      .nvdla_core_rst          (rst),
      .cfg_kernel_width        (cfg_kernel_width),
      .pool_in_pvld            (pool_in_pvld),
      .pool_in_prdy            (pool_in_prdy),
      .pool_in_data            (pool_in_data),
      .sum_in_pvld             (sum_in_pvld),
      .sum_in_prdy             (sum_in_prdy),
      .sum_a                   (sum_a),
      .sum_b                   (sum_b),
      .sum_out_pvld            (sum_out_pvld),
      .sum_out_prdy            (sum_out_prdy),
      .sum_z                   (sum_z),
      .pool_out_pvld           (pool_out_pvld),
      .pool_out_prdy           (pool_out_prdy),
      .pool_out_data           (pool_out_data)
`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
      ,
      .perf_stall_cnt          (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2*BW-1:0] obs, input logic [2*BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic real f2r(input logic [16:0] v);
      real r;
      int  e;
      r = 1.0 + real'(int'(v[9:0])) / 1024.0;
      e = int'(v[15:10]);
      while (e > 31) begin r = r * 2.0; e--; end
      while (e < 31) begin r = r / 2.0; e++; end
      return r;
   endfunction

   function automatic logic [16:0] r2f(input real rin);
      real r;
      int  e;
      int  m;
      r = rin;
      e = 31;
      while (r >= 2.0) begin r = r / 2.0; e++; end
      while (r < 1.0)  begin r = r * 2.0; e--; end
      m = $rtoi((r - 1.0) * 1024.0 + 0.5);
      return {1'b0, e[5:0], m[9:0]};
   endfunction

   function automatic logic [BW-1:0] add68(input logic [BW-1:0] a, input logic [BW-1:0] b);
      logic [BW-1:0] r;
      for (int l = 0; l < 4; l++) r[l*17 +: 17] = r2f(f2r(a[l*17 +: 17]) + f2r(b[l*17 +: 17]));
      return r;
   endfunction

   function automatic logic [BW-1:0] rep(input logic [16:0] v);
      return {4{v}};
   endfunction

   task automatic fail_now(input string tag);
      checks++;
      errors++;
      $error("FAIL %s bound expired", tag);
   endtask

   // Present one element and hold it until accepted; returns at posedge+1 after the accept edge.
   task automatic send_elem(input logic [BW-1:0] d);
      int n;
      n = 0;
      pool_in_pvld = 1'b1;
      pool_in_data = d;
      forever begin
         @(negedge clk);
         if (pool_in_prdy) break;
         n++;
         if (n > 300) begin
            fail_now("send_elem");
            break;
         end
      end
      @(posedge clk); #1;
      pool_in_pvld = 1'b0;
      pool_in_data = '0;
   endtask

   // Push expected operand pairs and window sum for win[0..k-1], then drive the window.
   task automatic send_window(input int k);
      logic [BW-1:0] acc;
      acc = win[0];
      for (int i = 1; i < k; i++) begin
         exp_pair.push_back({acc, win[i]});
         acc = add68(acc, win[i]);
      end
      exp_out.push_back(acc);
      cfg_kernel_width = 3'(k - 1);
      send_elem(win[0]);
      cfg_kernel_width = 3'(~(k - 1));
      for (int i = 1; i < k; i++) send_elem(win[i]);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_out.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_out.size() != 0) fail_now("drain");
      @(posedge clk); #1;
      chk("pairs_left", 136'(exp_pair.size()), 136'(0));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_in_prdy"},   136'(pool_in_prdy),  136'(0));
      chk({tag, "_sum_pvld"},  136'(sum_in_pvld),   136'(0));
      chk({tag, "_sum_ab"},    {sum_a, sum_b},      136'(0));
      chk({tag, "_out_rdy"},   136'(sum_out_prdy),  136'(0));
      chk({tag, "_out_pvld"},  136'(pool_out_pvld), 136'(0));
      chk({tag, "_out_data"},  136'(pool_out_data), 136'(0));
   endtask

   // Adder model: one operand pair at a time, result after a fixed or random delay; checks operands.
   initial begin
      logic            s_rst, hs_in, hs_out, busy;
      logic [BW-1:0]   op_a, op_b, res;
      logic [2*BW-1:0] pair;
      int              cnt;
      sum_in_prdy  = 1'b1;
      sum_out_pvld = 1'b0;
      sum_z        = '0;
      busy         = 1'b0;
      cnt          = 0;
      res          = '0;
      forever begin
         @(negedge clk);
         s_rst  = rst;
         hs_in  = sum_in_pvld && sum_in_prdy;
         hs_out = sum_out_pvld && sum_out_prdy;
         op_a   = sum_a;
         op_b   = sum_b;
         if (sum_in_pvld) sum_in_seen = 1'b1;
         if (!s_rst && ((sum_in_pvld && !sum_in_prdy) || (sum_out_prdy && !sum_out_pvld))) stall_obs++;
         if (!s_rst && hs_in) begin
            if (exp_pair.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL operands unexpected observed=%h", {op_a, op_b});
            end else begin
               pair = exp_pair.pop_front();
               chk("operands", {op_a, op_b}, pair);
            end
         end
         @(posedge clk); #1;
         if (s_rst) begin
            busy         = 1'b0;
            sum_out_pvld = 1'b0;
            sum_z        = '0;
         end else begin
            if (hs_out) begin
               sum_out_pvld = 1'b0;
               busy         = 1'b0;
            end
            if (hs_in) begin
               busy = 1'b1;
               res  = add68(op_a, op_b);
               cnt  = rand_lat ? int'($urandom_range(0, 5)) : lat_fixed - 1;
            end else if (busy && !sum_out_pvld) begin
               if (cnt == 0) begin
                  sum_out_pvld = 1'b1;
                  sum_z        = res;
               end else begin
                  cnt--;
               end
            end
         end
         sum_in_prdy = prdy_toggle ? !sum_in_prdy : 1'b1;
      end
   end

   // Window-sum scoreboard.
   always @(negedge clk) begin
      if (!rst && pool_out_pvld && pool_out_prdy) begin
         if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL window_sum unexpected observed=%h", pool_out_data);
         end else begin
            chk("window_sum", 136'(pool_out_data), 136'(exp_out.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vals = '{17'h07800, 17'h07C00, 17'h08000, 17'h07E00};
      rst              = 1'b1;
      cfg_kernel_width = 3'd0;
      pool_in_pvld     = 1'b1;
      pool_in_data     = rep(17'h07C00);
      pool_out_prdy    = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #1;
      pool_in_pvld = 1'b0;
      pool_in_data = '0;
      rst          = 1'b0;
      @(negedge clk);
      chk("idle_in_prdy", 136'(pool_in_prdy), 136'(1));
`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
      chk("perf_reset", 136'(perf_stall_cnt), 136'(0));
`endif
      @(posedge clk); #1;

      // K=1: pass-through, output one cycle after accept, adder untouched
      sum_in_seen = 1'b0;
      win[0] = rep(17'h07C00);
      send_window(1);
      @(negedge clk);
      chk("k1_latency", 136'(pool_out_pvld), 136'(1));
      chk("k1_data", 136'(pool_out_data), 136'(rep(17'h07C00)));
      wait_drain();
      chk("k1_no_adder", 136'(sum_in_seen), 136'(0));

      // K=3, 3-cycle adder: (1,1),(2,2) -> 4.0
      lat_fixed = 3;
      win[0] = rep(17'h07C00);
      win[1] = rep(17'h07C00);
      win[2] = rep(17'h08000);
      send_window(3);
      wait_drain();

      // K=2 with downstream stalled: output held, no input accepted
      pool_out_prdy = 1'b0;
      win[0] = rep(17'h08000);
      win[1] = rep(17'h07C00);
      send_window(2);
      n = 0;
      while (!pool_out_pvld && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      pool_in_pvld = 1'b1;
      pool_in_data = rep(17'h07800);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_pvld", 136'(pool_out_pvld), 136'(1));
         chk("stall_data", 136'(pool_out_data), 136'(rep(17'h08200)));
         chk("stall_in_prdy", 136'(pool_in_prdy), 136'(0));
         @(posedge clk); #1;
      end
      pool_in_pvld  = 1'b0;
      pool_in_data  = '0;
      pool_out_prdy = 1'b1;
      wait_drain();

      // K=4, toggling adder ready and random result delay
      prdy_toggle = 1'b1;
      rand_lat    = 1'b1;
      for (int i = 0; i < 4; i++) win[i] = rep(17'h07C00);
      send_window(4);
      // back-to-back windows with mixed lane values
      for (int w = 0; w < 4; w++) begin
         int k;
         k = (w == 0) ? 8 : (w == 1) ? 5 : (w == 2) ? 1 : 2;
         for (int i = 0; i < k; i++)
            for (int l = 0; l < 4; l++) win[i][l*17 +: 17] = vals[$urandom_range(0, 3)];
         send_window(k);
      end
      wait_drain();

`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
      // stall counter against observed blocked cycles
      rand_lat  = 1'b0;
      lat_fixed = 10;
      stall_obs = 0;
      perf_p0   = perf_stall_cnt;
      for (int i = 0; i < 3; i++) win[i] = rep(17'h07C00);
      send_window(3);
      wait_drain();
      chk("perf_count", 136'(perf_stall_cnt - perf_p0), 136'(stall_obs));
`endif

      // reset while waiting for an adder result
      prdy_toggle      = 1'b0;
      rand_lat         = 1'b0;
      lat_fixed        = 6;
      cfg_kernel_width = 3'd3;
      exp_pair.push_back({rep(17'h07C00), rep(17'h08000)});
      send_elem(rep(17'h07C00));
      send_elem(rep(17'h08000));
      @(negedge clk);
      chk("in_wait", 136'(sum_out_prdy), 136'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk_outputs_zero("midrst");
`ifdef NVDLA_PDP_POOL_SEQ_PERF_EN
      chk("perf_midrst", 136'(perf_stall_cnt), 136'(0));
`endif
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_pair.delete();
      exp_out.delete();
      rst       = 1'b0;
      lat_fixed = 2;
      win[0] = rep(17'h08000);
      win[1] = rep(17'h07C00);
      send_window(2);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
